rotleft_seq: RTL and testbench

- Iterative rotate-left engine; the inverse companion of the fixed rotate-right helpers in the SHA-256 datapath.
- Takes a WIDTH-bit word and a run-time rotate amount, and rotates left by up to STEP bits per clock.
- Returns the result over a valid/ready handshake.
- Used to undo sigma-function rotations in the verification and debug paths, and for variable-amount rotates without a full barrel shifter.

---
 rtl/rotleft_seq_if.sv | 25 ++
 rtl/rotleft_seq.sv | 102 ++++++++++
 tb/tb_rotleft_seq.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rotleft_seq_if.sv
// Request/result handshake bundle for the iterative rotate-left engine.
// The engine sits on the slave side; the producer/consumer sits on the master side.
interface rotleft_seq_if #(
   parameter int WIDTH = 32
);
   localparam int AW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [AW-1:0]    in_amt;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_data, in_amt, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_amt, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/rotleft_seq.sv
// Iterative rotate-left engine: rotates a word left by a run-time amount,
// at most STEP bit positions per clock, and returns it over valid/ready.
module rotleft_seq #(
   parameter int WIDTH = 32,
   parameter int STEP  = 1
) (
   input  logic         clk,
   input  logic         rst,
   rotleft_seq_if.slave bus,
   output logic         busy
);
   localparam int AW = $clog2(WIDTH);
   localparam logic [AW:0] STEP_W  = (AW+1)'(STEP);
   localparam logic [AW:0] WIDTH_W = (AW+1)'(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] data_q;
   logic [AW:0]      rem_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;

   logic [AW:0]      step_amt;
   logic [AW:0]      rem_next;
   logic [WIDTH-1:0] rot_data;

   // A zero step shifts right by WIDTH, which yields zero, so rot_data == data_q.
   always_comb begin
      step_amt = (rem_q < STEP_W) ? rem_q : STEP_W;
      rem_next = rem_q - step_amt;
      rot_data = (data_q << step_amt) | (data_q >> (WIDTH_W - step_amt));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         data_q      <= '0;
         rem_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  data_q     <= bus.in_data;
                  rem_q      <= {1'b0, bus.in_amt};
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  if (bus.in_amt == '0) begin
                     state       <= DONE;
                     out_valid_q <= 1'b1;
                  end else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               data_q <= rot_data;
               rem_q  <= rem_next;
               if (rem_next == '0) begin
                  state       <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = data_q;
   assign busy          = busy_q;

   // Handshake protocol properties: results persist under backpressure.
   a_hold_valid : assert property (@(posedge clk) disable iff (rst)
      (out_valid_q && !bus.out_ready) |=> out_valid_q);
   a_hold_data : assert property (@(posedge clk) disable iff (rst)
      (out_valid_q && !bus.out_ready) |=> $stable(data_q));
   a_exclusive : assert property (@(posedge clk) disable iff (rst)
      !(in_ready_q && out_valid_q));
endmodule

// File: tb/tb_rotleft_seq.sv
// Scoreboard bench for rotleft_seq: one instance with STEP=1, one with STEP=4.
// Expected words are queued when a request is driven and popped when out_valid appears.
module tb_rotleft_seq;
   logic clk;
   logic rst;
   logic busy1;
   logic busy4;

   int checks = 0;
   int errors = 0;

   logic [31:0] q1[$];
   logic [31:0] q4[$];

   rotleft_seq_if #(.WIDTH(32)) b1();
   rotleft_seq_if #(.WIDTH(32)) b4();

   rotleft_seq #(.WIDTH(32), .STEP(1)) dut1 (
      .clk  (clk),
      .rst  (rst),
      .bus  (b1.slave),
      .busy (busy1)
   );

   rotleft_seq #(.WIDTH(32), .STEP(4)) dut4 (
      .clk  (clk),
      .rst  (rst),
      .bus  (b4.slave),
      .busy (busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rotl32(input logic [31:0] x, input int k);
      int kk;
      kk = k % 32;
      if (kk == 0) return x;
      return (x << kk) | (x >> (32 - kk));
   endfunction

   function automatic logic [31:0] rotr32(input logic [31:0] x, input int k);
      return rotl32(x, (32 - (k % 32)) % 32);
   endfunction

   function automatic logic get_ov(input int sel);
      return (sel == 4) ? b4.out_valid : b1.out_valid;
   endfunction

   function automatic logic get_ir(input int sel);
      return (sel == 4) ? b4.in_ready : b1.in_ready;
   endfunction

   function automatic logic [31:0] get_od(input int sel);
      return (sel == 4) ? b4.out_data : b1.out_data;
   endfunction

   function automatic logic [31:0] pop_exp(input int sel);
      if (sel == 4) return q4.pop_front();
      return q1.pop_front();
   endfunction

   task automatic drive_in(input int sel, input logic v, input logic [31:0] d, input logic [4:0] a);
      if (sel == 4) begin
         b4.in_valid = v; b4.in_data = d; b4.in_amt = a;
      end else begin
         b1.in_valid = v; b1.in_data = d; b1.in_amt = a;
      end
   endtask

   // Waits for in_ready, presents one request for exactly one accept edge and queues its expected result.
   task automatic applyStimulus(input int sel, input logic [31:0] d, input logic [4:0] a, input logic [31:0] exp);
      int n;
      n = 0;
      while (!get_ir(sel) && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (!get_ir(sel)) begin
         checks++; errors++;
         $display("[TB] FAIL accept_timeout: in_ready got 0 required 1 (dut step %0d)", sel);
      end
      drive_in(sel, 1'b1, d, a);
      if (sel == 4) q4.push_back(exp); else q1.push_back(exp);
      @(posedge clk); #1;
      drive_in(sel, 1'b0, 32'h0, 5'd0);
   endtask

   task automatic wait_result(input int sel, input int limit, output int cycles, output logic ok);
      cycles = 0;
      while (!get_ov(sel) && cycles < limit) begin
         @(posedge clk); #1;
         cycles++;
      end
      ok = get_ov(sel);
   endtask

   task automatic test_reset();
      checks++;
      if (b1.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b required 1", b1.in_ready); end
      checks++;
      if (b1.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b required 0", b1.out_valid); end
      checks++;
      if (busy1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b required 0", busy1); end
      checks++;
      if (b1.out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h required 00000000", b1.out_data); end
      checks++;
      if (b4.out_valid !== 1'b0 || b4.in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL reset_step4: got valid=%b ready=%b required 0/1", b4.out_valid, b4.in_ready);
      end
   endtask

   task automatic test_basic_step1();
      int cyc; logic ok; logic [31:0] exp;
      applyStimulus(1, 32'h00000001, 5'd6, 32'h00000040);
      wait_result(1, 40, cyc, ok);
      exp = pop_exp(1);
      checks++;
      if (!ok || cyc != 6) begin errors++; $display("[TB] FAIL basic_latency: got %0d edges (valid=%b) required 6", cyc, ok); end
      checks++;
      if (b1.out_data !== exp) begin errors++; $display("[TB] FAIL basic_data: got %h required %h", b1.out_data, exp); end
      @(posedge clk); #1;
      checks++;
      if (b1.in_ready !== 1'b1 || b1.out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL basic_release: got ready=%b valid=%b required 1/0", b1.in_ready, b1.out_valid);
      end
   endtask

   task automatic test_inverse_sweep();
      int cyc; logic ok; logic [31:0] exp; logic [31:0] x; int k; int bad;
      applyStimulus(1, 32'h80000000, 5'd6, 32'h00000020);
      wait_result(1, 40, cyc, ok);
      exp = pop_exp(1);
      checks++;
      if (!ok || b1.out_data !== exp) begin errors++; $display("[TB] FAIL wrap_data: got %h required %h", b1.out_data, exp); end
      @(posedge clk); #1;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         x = $urandom;
         k = $urandom_range(0, 31);
         applyStimulus(1, rotr32(x, k), 5'(k), x);
         wait_result(1, 40, cyc, ok);
         exp = pop_exp(1);
         checks++;
         if (!ok || b1.out_data !== exp) begin
            errors++;
            if (bad < 5) $display("[TB] FAIL inverse_k%0d: got %h required %h", k, b1.out_data, exp);
            bad++;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_multistep();
      int cyc; logic ok; logic [31:0] exp;
      applyStimulus(4, 32'h12345678, 5'd6, 32'h8D159E04);
      wait_result(4, 40, cyc, ok);
      exp = pop_exp(4);
      checks++;
      if (!ok || cyc != 2) begin errors++; $display("[TB] FAIL step4_amt6_latency: got %0d edges required 2", cyc); end
      checks++;
      if (b4.out_data !== exp) begin errors++; $display("[TB] FAIL step4_amt6_data: got %h required %h", b4.out_data, exp); end
      @(posedge clk); #1;
      applyStimulus(4, 32'h12345678, 5'd31, 32'h091A2B3C);
      wait_result(4, 40, cyc, ok);
      exp = pop_exp(4);
      checks++;
      if (!ok || cyc != 8) begin errors++; $display("[TB] FAIL step4_amt31_latency: got %0d edges required 8", cyc); end
      checks++;
      if (b4.out_data !== exp) begin errors++; $display("[TB] FAIL step4_amt31_data: got %h required %h", b4.out_data, exp); end
      @(posedge clk); #1;
      checks++;
      if (b4.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL step4_release: got %b required 1", b4.in_ready); end
   endtask

   task automatic test_back_to_back();
      int cyc; logic ok; logic [31:0] exp;
      b1.out_ready = 1'b0;
      drive_in(1, 1'b1, 32'hDEADBEEF, 5'd0);
      q1.push_back(32'hDEADBEEF);
      @(posedge clk); #1;
      exp = pop_exp(1);
      checks++;
      if (b1.out_valid !== 1'b1 || b1.out_data !== exp) begin
         errors++; $display("[TB] FAIL zero_amt: got valid=%b data=%h required 1/%h", b1.out_valid, b1.out_data, exp);
      end
      drive_in(1, 1'b1, 32'h00000003, 5'd2);
      repeat (2) begin
         @(posedge clk); #1;
         checks++;
         if (b1.in_ready !== 1'b0 || b1.out_valid !== 1'b1 || b1.out_data !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL held_request: got ready=%b valid=%b data=%h required 0/1/deadbeef", b1.in_ready, b1.out_valid, b1.out_data);
         end
      end
      b1.out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (b1.in_ready !== 1'b1 || b1.out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL b2b_handshake: got ready=%b valid=%b required 1/0", b1.in_ready, b1.out_valid);
      end
      q1.push_back(32'h0000000C);
      @(posedge clk); #1;
      drive_in(1, 1'b0, 32'h0, 5'd0);
      checks++;
      if (busy1 !== 1'b1 || b1.in_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL b2b_accept: got busy=%b ready=%b required 1/0", busy1, b1.in_ready);
      end
      wait_result(1, 40, cyc, ok);
      exp = pop_exp(1);
      checks++;
      if (!ok || cyc != 2 || b1.out_data !== exp) begin
         errors++; $display("[TB] FAIL b2b_second: got %h after %0d edges required %h after 2", b1.out_data, cyc, exp);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      int cyc; logic ok; logic [31:0] exp;
      b1.out_ready = 1'b0;
      applyStimulus(1, 32'h00000001, 5'd6, 32'h00000040);
      wait_result(1, 40, cyc, ok);
      exp = pop_exp(1);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (b1.out_valid !== 1'b1 || b1.out_data !== exp || b1.in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL backpressure_c%0d: got valid=%b data=%h ready=%b required 1/%h/0", i, b1.out_valid, b1.out_data, b1.in_ready, exp);
         end
         @(posedge clk); #1;
      end
      b1.out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (b1.out_valid !== 1'b0 || b1.in_ready !== 1'b1 || busy1 !== 1'b0) begin
         errors++; $display("[TB] FAIL backpressure_release: got valid=%b ready=%b busy=%b required 0/1/0", b1.out_valid, b1.in_ready, busy1);
      end
   endtask

   task automatic test_reset_mid();
      int cyc; logic ok; logic [31:0] exp;
      applyStimulus(1, 32'hA5A5F00F, 5'd20, rotl32(32'hA5A5F00F, 20));
      repeat (2) @(posedge clk);
      #4;
      checks++;
      if (busy1 !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy: got %b required 1", busy1); end
      rst = 1'b1;
      q1.delete();
      #1;
      checks++;
      if (b1.in_ready !== 1'b1 || b1.out_valid !== 1'b0 || busy1 !== 1'b0 || b1.out_data !== 32'h0) begin
         errors++;
         $display("[TB] FAIL mid_reset: got ready=%b valid=%b busy=%b data=%h required 1/0/0/00000000", b1.in_ready, b1.out_valid, busy1, b1.out_data);
      end
      #2;
      rst = 1'b0;
      @(posedge clk); #1;
      applyStimulus(1, 32'h00000001, 5'd1, 32'h00000002);
      wait_result(1, 40, cyc, ok);
      exp = pop_exp(1);
      checks++;
      if (!ok || cyc != 1 || b1.out_data !== exp) begin
         errors++; $display("[TB] FAIL post_reset: got %h after %0d edges required %h after 1", b1.out_data, cyc, exp);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      drive_in(1, 1'b0, 32'h0, 5'd0);
      drive_in(4, 1'b0, 32'h0, 5'd0);
      b1.out_ready = 1'b1;
      b4.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      test_basic_step1();
      test_inverse_sweep();
      test_multistep();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
